// File: rtl/axi_ic_wr_sched_pkg.sv
// Shared types and constants for the AXI interconnect write-path scheduler.
package axi_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wr_sched_state_e;

  localparam int unsigned DefMaxOutstanding = 32'd4;
  localparam int unsigned DefTimeoutCycles  = 32'd256;

  // A single master still needs a one-bit select.
  function automatic int unsigned grant_width(input int unsigned num_masters);
    return (num_masters > 32'd1) ? $clog2(num_masters) : 32'd1;
  endfunction

endpackage

// File: rtl/axi_ic_wr_sched_if.sv
// Request/handshake and grant bundle between the write path and one slave's scheduler.
interface axi_ic_wr_sched_if #(
  parameter int unsigned NumMasters     = 32'd2,
  parameter int unsigned MaxOutstanding = axi_ic_pkg::DefMaxOutstanding
);
  localparam int unsigned GrantWidth = axi_ic_pkg::grant_width(NumMasters);
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 32'd1);

  logic [NumMasters-1:0] awvalid_i;
  logic                  awready_i;
  logic                  wvalid_i;
  logic                  wready_i;
  logic                  wlast_i;
  logic                  bvalid_i;
  logic                  bready_i;
  logic [NumMasters-1:0] grant_o;
  logic [GrantWidth-1:0] grant_bin_o;
  logic                  aw_en_o;
  logic                  w_en_o;
  logic                  busy_o;
  logic [CntWidth-1:0]   outstanding_o;
  logic                  timeout_o;

  modport slave (
    input  awvalid_i, awready_i, wvalid_i, wready_i, wlast_i, bvalid_i, bready_i,
    output grant_o, grant_bin_o, aw_en_o, w_en_o, busy_o, outstanding_o, timeout_o
  );

  modport master (
    output awvalid_i, awready_i, wvalid_i, wready_i, wlast_i, bvalid_i, bready_i,
    input  grant_o, grant_bin_o, aw_en_o, w_en_o, busy_o, outstanding_o, timeout_o
  );

endinterface

// File: rtl/axi_ic_wr_sched_rr_pick.sv
// Combinational cyclic priority search: first requester strictly after the pointer wins.
module rr_pick #(
  parameter int unsigned NumMasters = 32'd2,
  parameter int unsigned GrantWidth = 32'd1
) (
  input  logic [NumMasters-1:0] req,
  input  logic [GrantWidth-1:0] pointer,
  output logic [NumMasters-1:0] onehot,
  output logic [GrantWidth-1:0] binary,
  output logic                  any
);

  logic [GrantWidth-1:0] idx_s;

  // Walk pointer+1 .. pointer+NumMasters (mod NumMasters), keep the first hit.
  always_comb begin
    onehot = '0;
    binary = '0;
    any    = 1'b0;
    idx_s  = '0;
    for (int unsigned k = 32'd1; k <= NumMasters; k++) begin
      idx_s = GrantWidth'((32'(pointer) + k) % NumMasters);
      if (!any && req[idx_s]) begin
        onehot[idx_s] = 1'b1;
        binary        = idx_s;
        any           = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/axi_ic_wr_sched.sv
// Per-slave write scheduler: round-robin AW grant held through the W burst, outstanding-write bound.
// Optional W-stall watchdog enabled by defining AXI_WR_SCHED_TIMEOUT_EN.
module axi_ic_wr_sched #(
  parameter int unsigned NumMasters     = 32'd2,
  parameter int unsigned MaxOutstanding = axi_ic_pkg::DefMaxOutstanding
`ifdef AXI_WR_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles  = axi_ic_pkg::DefTimeoutCycles
`endif
) (
  input logic              aclk,
  input logic              rst_n,
  axi_ic_wr_sched_if.slave bus
);
  import axi_ic_pkg::*;

  localparam int unsigned GrantWidth = grant_width(NumMasters);
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 32'd1);

  wr_sched_state_e       state_r, state_next_s;
  logic [GrantWidth-1:0] ptr_r, ptr_next_s;
  logic [NumMasters-1:0] grant_r, grant_next_s;
  logic [GrantWidth-1:0] grant_bin_r, grant_bin_next_s;
  logic [CntWidth-1:0]   cnt_r, cnt_next_s;
  logic                  aw_en_r, w_en_r, busy_r, timeout_r;

  logic [NumMasters-1:0] pick_onehot_s;
  logic [GrantWidth-1:0] pick_bin_s;
  logic                  pick_any_s;
  logic                  can_grant_s, aw_hs_s, w_hs_s, b_hs_s, burst_done_s, timeout_fire_s;

  rr_pick #(
    .NumMasters (NumMasters),
    .GrantWidth (GrantWidth)
  ) u_pick (
    .req     (bus.awvalid_i),
    .pointer (ptr_r),
    .onehot  (pick_onehot_s),
    .binary  (pick_bin_s),
    .any     (pick_any_s)
  );

  assign can_grant_s  = pick_any_s && (cnt_r < CntWidth'(MaxOutstanding));
  assign aw_hs_s      = (state_r == ADDR) && bus.awvalid_i[grant_bin_r] && bus.awready_i;
  assign w_hs_s       = (state_r == DATA) && bus.wvalid_i && bus.wready_i;
  assign burst_done_s = w_hs_s && bus.wlast_i;
  assign b_hs_s       = bus.bvalid_i && bus.bready_i;

`ifdef AXI_WR_SCHED_TIMEOUT_EN
  localparam int unsigned WdWidth = (TimeoutCycles > 32'd1) ? $clog2(TimeoutCycles) : 32'd1;

  logic [WdWidth-1:0] wd_r;

  assign timeout_fire_s = (state_r == DATA) && !w_hs_s && (wd_r == WdWidth'(TimeoutCycles - 32'd1));

  // Watchdog: counts idle DATA cycles; outside DATA it sits at zero, so entry starts fresh.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= '0;
    end else if ((state_r != DATA) || w_hs_s || timeout_fire_s) begin
      wd_r <= '0;
    end else begin
      wd_r <= wd_r + WdWidth'(1);
    end
  end
`else
  assign timeout_fire_s = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= GrantWidth'(NumMasters - 32'd1);
      grant_r     <= '0;
      grant_bin_r <= '0;
      cnt_r       <= '0;
      aw_en_r     <= 1'b0;
      w_en_r      <= 1'b0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      ptr_r       <= ptr_next_s;
      grant_r     <= grant_next_s;
      grant_bin_r <= grant_bin_next_s;
      cnt_r       <= cnt_next_s;
      aw_en_r     <= (state_next_s == ADDR);
      w_en_r      <= (state_next_s == DATA);
      busy_r      <= (state_next_s != IDLE);
      timeout_r   <= timeout_fire_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (can_grant_s) begin
          state_next_s = ADDR;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADDR: begin
        if (aw_hs_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = ADDR;
        end
      end
      DATA: begin
        if (burst_done_s || timeout_fire_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DATA;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Grant, pointer and outstanding-count updates.
  always_comb begin
    grant_next_s     = grant_r;
    grant_bin_next_s = grant_bin_r;
    ptr_next_s       = ptr_r;
    cnt_next_s       = cnt_r;
    case (state_r)
      IDLE: begin
        if (can_grant_s) begin
          grant_next_s     = pick_onehot_s;
          grant_bin_next_s = pick_bin_s;
        end else begin
          grant_next_s = '0;
        end
      end
      ADDR: grant_next_s = grant_r;
      DATA: begin
        // A stalled master is skipped exactly like a finished one.
        if (burst_done_s || timeout_fire_s) begin
          grant_next_s = '0;
          ptr_next_s   = grant_bin_r;
        end else begin
          grant_next_s = grant_r;
        end
      end
      default: grant_next_s = '0;
    endcase

    case ({aw_hs_s, b_hs_s})
      2'b10: cnt_next_s = cnt_r + CntWidth'(1);
      2'b01: begin
        if (cnt_r != '0) begin
          cnt_next_s = cnt_r - CntWidth'(1);
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: cnt_next_s = cnt_r;
    endcase
  end

  assign bus.grant_o       = grant_r;
  assign bus.grant_bin_o   = grant_bin_r;
  assign bus.aw_en_o       = aw_en_r;
  assign bus.w_en_o        = w_en_r;
  assign bus.busy_o        = busy_r;
  assign bus.outstanding_o = cnt_r;
  assign bus.timeout_o     = timeout_r;

endmodule

// File: tb/tb_axi_ic_wr_sched.sv
// Directed bench for axi_ic_wr_sched: per-cycle vector table plus hand-written corner sequences.
module tb_axi_ic_wr_sched;

  logic aclk;
  logic rst_n;
  int   tests;
  int   fails;

  axi_ic_wr_sched_if #(.NumMasters(2), .MaxOutstanding(2)) bus ();

  axi_ic_wr_sched #(
    .NumMasters     (2),
    .MaxOutstanding (2)
`ifdef AXI_WR_SCHED_TIMEOUT_EN
    ,
    .TimeoutCycles  (16)
`endif
  ) dut (
    .aclk  (aclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0] aw;
    logic       awr, wv, wr, wl, bv, br;
    logic [1:0] g;
    logic       gb, ae, we, bz;
    logic [1:0] oc;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic [1:0] aw, input logic awr, wv, wr, wl, bv, br,
                            input logic [1:0] g, input logic gb, ae, we, bz, input logic [1:0] oc);
    vec_t e;
    e.aw = aw; e.awr = awr; e.wv = wv; e.wr = wr; e.wl = wl; e.bv = bv; e.br = br;
    e.g = g; e.gb = gb; e.ae = ae; e.we = we; e.bz = bz; e.oc = oc;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.awvalid_i = 2'b00; bus.awready_i = 1'b0;
    bus.wvalid_i = 1'b0; bus.wready_i = 1'b0; bus.wlast_i = 1'b0;
    bus.bvalid_i = 1'b0; bus.bready_i = 1'b0;
  endtask

  task automatic write_burst(input int m, input int beats);
    int n;
    bus.awvalid_i = 2'b00;
    bus.awvalid_i[m] = 1'b1;
    bus.awready_i = 1'b1;
    n = 0;
    while (bus.grant_o[m] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk($sformatf("grant_wait_m%0d", m), {7'd0, bus.grant_o[m]}, 8'd1);
    step();
    bus.awvalid_i = 2'b00; bus.awready_i = 1'b0;
    bus.wvalid_i = 1'b1; bus.wready_i = 1'b1;
    for (int i = 0; i < beats; i++) begin
      bus.wlast_i = (i == beats - 1);
      step();
    end
    bus.wvalid_i = 1'b0; bus.wready_i = 1'b0; bus.wlast_i = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Test 2: lone m1, AW on second cycle, 3 beats
    v(2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b1,1'b0,1'b1,2'd0);
    v(2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b1,1'b1,2'd1);
    v(2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b1,1'b1,2'd1);
    v(2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b1,1'b1,2'd1);
    v(2'b00,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 2'b00,1'b1,1'b0,1'b0,1'b0,2'd1);
    v(2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 2'b00,1'b1,1'b0,1'b0,1'b0,2'd0);
    // Test 1: both request, order m0, m1, m0 with 4-beat bursts
    v(2'b11,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b1,1'b0,1'b1,2'd0);
    v(2'b11,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,1'b1,1'b1,2'd1);
    for (int i = 0; i < 3; i++)
      v(2'b11,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,1'b1,1'b1,2'd1);
    v(2'b11,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b00,1'b0,1'b0,1'b0,1'b0,2'd0);
    v(2'b11,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b1,1'b0,1'b1,2'd0);
    v(2'b11,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b1,1'b1,2'd1);
    v(2'b11,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b1,1'b1,2'd1);
    for (int i = 0; i < 3; i++)
      v(2'b11,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b1,1'b1,2'd1);
    v(2'b11,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b00,1'b1,1'b0,1'b0,1'b0,2'd0);
    v(2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b1,1'b0,1'b1,2'd0);
    v(2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b1,1'b0,1'b1,2'd0);
    v(2'b11,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,1'b1,1'b1,2'd1);
    for (int i = 0; i < 3; i++)
      v(2'b11,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,1'b0,1'b0,1'b1,1'b1,2'd1);
    v(2'b11,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b00,1'b0,1'b0,1'b0,1'b0,2'd0);
    v(2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,1'b0,2'd0);

    // Reset values
    step();
    chk("rst.grant", {6'd0, bus.grant_o}, 8'd0);
    chk("rst.grant_bin", {7'd0, bus.grant_bin_o}, 8'd0);
    chk("rst.en", {6'd0, bus.aw_en_o, bus.w_en_o}, 8'd0);
    chk("rst.busy", {7'd0, bus.busy_o}, 8'd0);
    chk("rst.outstanding", {6'd0, bus.outstanding_o}, 8'd0);
    chk("rst.timeout", {7'd0, bus.timeout_o}, 8'd0);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.awvalid_i = vecs[i].aw; bus.awready_i = vecs[i].awr;
      bus.wvalid_i = vecs[i].wv; bus.wready_i = vecs[i].wr; bus.wlast_i = vecs[i].wl;
      bus.bvalid_i = vecs[i].bv; bus.bready_i = vecs[i].br;
      step();
      chk($sformatf("vec%0d.grant", i), {6'd0, bus.grant_o}, {6'd0, vecs[i].g});
      chk($sformatf("vec%0d.grant_bin", i), {7'd0, bus.grant_bin_o}, {7'd0, vecs[i].gb});
      chk($sformatf("vec%0d.aw_en", i), {7'd0, bus.aw_en_o}, {7'd0, vecs[i].ae});
      chk($sformatf("vec%0d.w_en", i), {7'd0, bus.w_en_o}, {7'd0, vecs[i].we});
      chk($sformatf("vec%0d.busy", i), {7'd0, bus.busy_o}, {7'd0, vecs[i].bz});
      chk($sformatf("vec%0d.outstanding", i), {6'd0, bus.outstanding_o}, {6'd0, vecs[i].oc});
    end
    idle_inputs();

    // Test 3: outstanding limit of 2 blocks the third grant
    write_burst(0, 1);
    write_burst(1, 1);
    chk("lim.outstanding_full", {6'd0, bus.outstanding_o}, 8'd2);
    bus.awvalid_i = 2'b01;
    for (int i = 0; i < 4; i++) step();
    chk("lim.no_grant", {6'd0, bus.grant_o}, 8'd0);
    chk("lim.not_busy", {7'd0, bus.busy_o}, 8'd0);
    bus.bvalid_i = 1'b1; bus.bready_i = 1'b1;
    step();
    bus.bvalid_i = 1'b0; bus.bready_i = 1'b0;
    chk("lim.b_dec", {6'd0, bus.outstanding_o}, 8'd1);
    chk("lim.grant_not_yet", {6'd0, bus.grant_o}, 8'd0);
    step();
    chk("lim.grant_after_b", {6'd0, bus.grant_o}, 8'd1);
    bus.awready_i = 1'b1;
    step();
    chk("lim.outstanding_refill", {6'd0, bus.outstanding_o}, 8'd2);
    bus.awvalid_i = 2'b00; bus.awready_i = 1'b0;
    bus.wvalid_i = 1'b1; bus.wready_i = 1'b1; bus.wlast_i = 1'b1;
    step();
    idle_inputs();

    // Test 4: simultaneous AW/B handshakes, then B at zero
    bus.bvalid_i = 1'b1; bus.bready_i = 1'b1;
    step();
    chk("cnt.to_one", {6'd0, bus.outstanding_o}, 8'd1);
    bus.bvalid_i = 1'b0; bus.bready_i = 1'b0;
    bus.awvalid_i = 2'b10;
    step();
    chk("cnt.grant_m1", {6'd0, bus.grant_o}, 8'd2);
    bus.bvalid_i = 1'b1; bus.bready_i = 1'b1; bus.awready_i = 1'b1;
    step();
    chk("cnt.aw_and_b", {6'd0, bus.outstanding_o}, 8'd1);
    chk("cnt.in_data", {7'd0, bus.w_en_o}, 8'd1);
    idle_inputs();
    bus.wvalid_i = 1'b1; bus.wready_i = 1'b1; bus.wlast_i = 1'b1;
    step();
    idle_inputs();
    bus.bvalid_i = 1'b1; bus.bready_i = 1'b1;
    step();
    chk("cnt.to_zero", {6'd0, bus.outstanding_o}, 8'd0);
    step();
    chk("cnt.no_underflow", {6'd0, bus.outstanding_o}, 8'd0);
    idle_inputs();

    // Test 5: async reset during DATA beat 2
    bus.awvalid_i = 2'b01;
    step();
    bus.awready_i = 1'b1;
    step();
    bus.awvalid_i = 2'b00; bus.awready_i = 1'b0;
    bus.wvalid_i = 1'b1; bus.wready_i = 1'b1;
    step();
    chk("arst.in_data", {7'd0, bus.w_en_o}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.grant", {6'd0, bus.grant_o}, 8'd0);
    chk("arst.en", {6'd0, bus.aw_en_o, bus.w_en_o}, 8'd0);
    chk("arst.busy", {7'd0, bus.busy_o}, 8'd0);
    chk("arst.outstanding", {6'd0, bus.outstanding_o}, 8'd0);
    @(posedge aclk);
    #2 rst_n = 1'b1;
    idle_inputs();
    bus.awvalid_i = 2'b11;
    step();
    chk("arst.m0_first", {6'd0, bus.grant_o}, 8'd1);
    chk("arst.m0_bin", {7'd0, bus.grant_bin_o}, 8'd0);

    // Test 6: m0 stalls W after one beat while m1 waits
    bus.awready_i = 1'b1;
    step();
    bus.awvalid_i = 2'b10; bus.awready_i = 1'b0;
    bus.wvalid_i = 1'b1; bus.wready_i = 1'b1;
    step();
    bus.wvalid_i = 1'b0; bus.wready_i = 1'b0;
`ifdef AXI_WR_SCHED_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      seen = bus.timeout_o;
    end
    chk("wd.pulse_delay", n[7:0], 8'd16);
    chk("wd.grant_cleared", {6'd0, bus.grant_o}, 8'd0);
    chk("wd.outstanding_kept", {6'd0, bus.outstanding_o}, 8'd1);
    step();
    chk("wd.pulse_width", {7'd0, bus.timeout_o}, 8'd0);
    chk("wd.m1_next", {6'd0, bus.grant_o}, 8'd2);
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen = seen | bus.timeout_o;
    end
    chk("nowd.timeout_low", {7'd0, seen}, 8'd0);
    chk("nowd.still_data", {7'd0, bus.w_en_o}, 8'd1);
    bus.wvalid_i = 1'b1; bus.wready_i = 1'b1; bus.wlast_i = 1'b1;
    step();
    bus.wvalid_i = 1'b0; bus.wready_i = 1'b0; bus.wlast_i = 1'b0;
    step();
    chk("nowd.m1_next", {6'd0, bus.grant_o}, 8'd2);
`endif
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
